// File: rtl/intr_pkg.sv
// Shared types and limits for the MCU interrupt controller.
package intr_pkg;

  localparam int MAX_IRQ = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } intr_st_t;

endpackage

// File: rtl/intr_ctrl_if.sv
// Control-unit <-> interrupt-controller signal bundle; master = control unit side.
interface intr_ctrl_if #(
  parameter int N_IRQ = 4,
  parameter int ID_W  = 2
);
  logic [N_IRQ-1:0] irq;
  logic             ld_mask;
  logic [N_IRQ-1:0] mask_in;
  logic             sei;
  logic             cli;
  logic             int_ack;
  logic             retie;
  logic             retid;
  logic             c_flag;
  logic             z_flag;
  logic             intr;
  logic [ID_W-1:0]  intr_id;
  logic             i_flag;
  logic             shad_c;
  logic             shad_z;
  logic             flg_restore;
  logic [N_IRQ-1:0] pending;

  modport master (
    output irq, ld_mask, mask_in, sei, cli, int_ack, retie, retid, c_flag, z_flag,
    input  intr, intr_id, i_flag, shad_c, shad_z, flg_restore, pending
  );

  modport slave (
    input  irq, ld_mask, mask_in, sei, cli, int_ack, retie, retid, c_flag, z_flag,
    output intr, intr_id, i_flag, shad_c, shad_z, flg_restore, pending
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req (index 0 wins).
// Purely combinational.
module irq_prio_enc #(
  parameter int N_IRQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_IRQ-1:0] req,
  output logic             vld,
  output logic [ID_W-1:0]  idx
);

  // Scanning downward leaves the lowest set index as the final assignment.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        vld = 1'b1;
        idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Edge-latched, fixed-priority interrupt controller with I flag and C/Z shadow flags.
// IRQ rise -> PENDING after one edge -> INTR after the next; INTR_ID frozen while requesting.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int N_IRQ = 4,
  parameter int ID_W  = 2
) (
  input  logic        clk,
  input  logic        rst,
  intr_ctrl_if.slave  bus
);

  intr_st_t         state, state_nxt;
  logic [N_IRQ-1:0] irq_q, pending, mask, evt, elig, clr;
  logic             win_vld;
  logic [ID_W-1:0]  win_idx, intr_id;
  logic             intr, i_flag, shad_c, shad_z, flg_restore;
  logic             take_ack, reti;

  assign evt      = bus.irq & ~irq_q;
  assign elig     = pending & mask;
  assign take_ack = (state == ST_REQ) && bus.int_ack;
  assign reti     = (state == ST_SERVICE) && (bus.retie || bus.retid);

  irq_prio_enc #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_prio_enc (
    .req (elig),
    .vld (win_vld),
    .idx (win_idx)
  );

  always_comb begin
    clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      clr[i] = take_ack && (intr_id == ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Leaving REQ on a masked grant keeps the pending bit for later service.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (i_flag && win_vld) state_nxt = ST_REQ;
      ST_REQ:     if (bus.int_ack)                   state_nxt = ST_SERVICE;
                  else if (bus.cli || !mask[intr_id]) state_nxt = ST_IDLE;
      ST_SERVICE: if (bus.retie || bus.retid)        state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q       <= '0;
      pending     <= '0;
      mask        <= '1;
      intr_id     <= '0;
      intr        <= 1'b0;
      i_flag      <= 1'b0;
      shad_c      <= 1'b0;
      shad_z      <= 1'b0;
      flg_restore <= 1'b0;
    end else begin
      irq_q       <= bus.irq;
      // OR-ing events after the clear lets a same-cycle new edge survive the ACK.
      pending     <= (pending & ~clr) | evt;
      intr        <= (state_nxt == ST_REQ);
      flg_restore <= reti;
      if (bus.ld_mask) mask <= bus.mask_in;
      if (state == ST_IDLE && state_nxt == ST_REQ) intr_id <= win_idx;
      if (take_ack) begin
        shad_c <= bus.c_flag;
        shad_z <= bus.z_flag;
      end
      if (take_ack)     i_flag <= 1'b0;
      else if (reti)    i_flag <= !bus.retid;
      else if (bus.cli) i_flag <= 1'b0;
      else if (bus.sei) i_flag <= 1'b1;
    end
  end

  assign bus.intr        = intr;
  assign bus.intr_id     = intr_id;
  assign bus.i_flag      = i_flag;
  assign bus.shad_c      = shad_c;
  assign bus.shad_z      = shad_z;
  assign bus.flg_restore = flg_restore;
  assign bus.pending     = pending;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl; expected values are hand-derived.
module tb_intr_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  intr_ctrl_if #(.N_IRQ(4), .ID_W(2)) bus ();

  intr_ctrl #(.N_IRQ(4), .ID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.irq = '0; bus.ld_mask = 0; bus.mask_in = '0; bus.sei = 0; bus.cli = 0;
    bus.int_ack = 0; bus.retie = 0; bus.retid = 0; bus.c_flag = 0; bus.z_flag = 0;

    // Reset state
    step(2);
    rst = 0;
    check("rst_intr",    bus.intr, 0);
    check("rst_id",      bus.intr_id, 0);
    check("rst_iflag",   bus.i_flag, 0);
    check("rst_shad",    {bus.shad_c, bus.shad_z}, 0);
    check("rst_restore", bus.flg_restore, 0);
    check("rst_pending", bus.pending, 0);

    // 1: latency, single source
    bus.sei = 1; step(); bus.sei = 0;
    check("t1_iflag", bus.i_flag, 1);
    bus.irq = 4'b0100; step();
    check("t1_pend_k", bus.pending, 4'b0100);
    check("t1_intr_k", bus.intr, 0);
    step();
    check("t1_intr_k1", bus.intr, 1);
    check("t1_id", bus.intr_id, 2);
    bus.int_ack = 1; step(); bus.int_ack = 0; bus.irq = 0;
    check("t1_pend_ack", bus.pending, 0);
    check("t1_iflag_ack", bus.i_flag, 0);
    check("t1_intr_ack", bus.intr, 0);
    bus.retie = 1; step(); bus.retie = 0;
    check("t1_restore", bus.flg_restore, 1);
    check("t1_iflag_reti", bus.i_flag, 1);
    step();
    check("t1_restore_end", bus.flg_restore, 0);

    // 2: simultaneous rises, priority
    bus.irq = 4'b1010; step();
    check("t2_pend", bus.pending, 4'b1010);
    step();
    check("t2_id1", bus.intr_id, 1);
    check("t2_intr1", bus.intr, 1);
    bus.int_ack = 1; step(); bus.int_ack = 0;
    check("t2_pend_ack", bus.pending, 4'b1000);
    bus.retie = 1; step(); bus.retie = 0;
    step();
    check("t2_intr3", bus.intr, 1);
    check("t2_id3", bus.intr_id, 3);
    bus.int_ack = 1; step(); bus.int_ack = 0;
    bus.retie = 1; step(); bus.retie = 0;
    bus.irq = 0; step();
    check("t2_pend_clean", bus.pending, 0);

    // 3: late higher-priority arrival waits
    bus.irq = 4'b0100; step(2);
    check("t3_id2", bus.intr_id, 2);
    bus.irq = 4'b0101; step();
    check("t3_pend", bus.pending, 4'b0101);
    check("t3_id_frozen", bus.intr_id, 2);
    step();
    check("t3_id_frozen2", bus.intr_id, 2);
    bus.int_ack = 1; step(); bus.int_ack = 0;
    check("t3_pend_ack", bus.pending, 4'b0001);
    bus.retie = 1; step(); bus.retie = 0;
    step();
    check("t3_intr0", bus.intr, 1);
    check("t3_id0", bus.intr_id, 0);
    bus.int_ack = 1; step(); bus.int_ack = 0;
    bus.retie = 1; step(); bus.retie = 0;
    bus.irq = 0; step();

    // 4: shadow flags and RETID
    bus.irq = 4'b0010; step(2);
    check("t4_id1", bus.intr_id, 1);
    bus.c_flag = 1; bus.z_flag = 0; bus.int_ack = 1; step(); bus.int_ack = 0;
    bus.c_flag = 0; bus.z_flag = 1;
    check("t4_shad_ack", {bus.shad_c, bus.shad_z}, 2'b10);
    bus.irq = 4'b1010; step();
    check("t4_shad_isr", {bus.shad_c, bus.shad_z}, 2'b10);
    check("t4_pend_isr", bus.pending, 4'b1000);
    check("t4_no_nest", bus.intr, 0);
    bus.retid = 1; step(); bus.retid = 0;
    check("t4_restore", bus.flg_restore, 1);
    check("t4_shad_reti", {bus.shad_c, bus.shad_z}, 2'b10);
    check("t4_iflag", bus.i_flag, 0);
    step();
    check("t4_restore_end", bus.flg_restore, 0);
    step(2);
    check("t4_intr_off", bus.intr, 0);
    check("t4_pend_kept", bus.pending, 4'b1000);

    // 5: CLI withdraws request, SEI restores it
    bus.sei = 1; step(); bus.sei = 0;
    check("t5_intr_sei", bus.intr, 0);
    step();
    check("t5_intr_on", bus.intr, 1);
    check("t5_id3", bus.intr_id, 3);
    bus.cli = 1; step(); bus.cli = 0;
    check("t5_intr_cli", bus.intr, 0);
    check("t5_pend_cli", bus.pending, 4'b1000);
    check("t5_iflag_cli", bus.i_flag, 0);
    step();
    check("t5_intr_idle", bus.intr, 0);
    bus.sei = 1; step(); bus.sei = 0;
    step();
    check("t5_intr_again", bus.intr, 1);
    check("t5_id_again", bus.intr_id, 3);

    // 6: ACK coincident with new rise, then reset in SERVICE
    bus.irq = 4'b0010; step();
    check("t6_pend_pre", bus.pending, 4'b1000);
    bus.irq = 4'b1010; bus.c_flag = 1; bus.z_flag = 1; bus.int_ack = 1; step();
    bus.int_ack = 0;
    check("t6_pend_setwins", bus.pending, 4'b1000);
    check("t6_shad", {bus.shad_c, bus.shad_z}, 2'b11);
    rst = 1; bus.retie = 1; bus.irq = 0; step(); rst = 0; bus.retie = 0;
    check("t6_rst_intr", bus.intr, 0);
    check("t6_rst_iflag", bus.i_flag, 0);
    check("t6_rst_shad", {bus.shad_c, bus.shad_z}, 0);
    check("t6_rst_restore", bus.flg_restore, 0);
    check("t6_rst_pend", bus.pending, 0);
    check("t6_rst_id", bus.intr_id, 0);

    // 7: masking the granted source drops the request but keeps it pending
    bus.sei = 1; step(); bus.sei = 0;
    bus.irq = 4'b0100; step(2);
    check("t7_intr", bus.intr, 1);
    bus.ld_mask = 1; bus.mask_in = 4'b1011; step(); bus.ld_mask = 0;
    step();
    check("t7_intr_masked", bus.intr, 0);
    check("t7_pend_kept", bus.pending, 4'b0100);
    step();
    check("t7_stay_idle", bus.intr, 0);
    bus.ld_mask = 1; bus.mask_in = 4'b1111; step(); bus.ld_mask = 0;
    step();
    check("t7_intr_unmask", bus.intr, 1);
    check("t7_id2", bus.intr_id, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
